// File: rtl/mac_lane_array.sv
// mac_lane_array: SIZE-lane signed multiply-accumulate datapath, the stage
// after the MAC sequencer. Each lane has a three-stage operand/product/
// accumulator pipeline that is advanced by the sequencer strobes. At the end
// of a job the accumulators are published through a valid/ready result port.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   clear               zero prod/acc/sat/overrun for a new job
//   load_en/mult_en/acc_en  pipeline stage strobes (independent)
//   memsel[SIZE]        per-lane enable, bit i gates lane i
//   done                end-of-job pulse; captures acc into result
//   a_in/b_in           packed signed operands, lane i at [i*DATA_W +: DATA_W]
//   result              captured accumulators, lane i at [i*ACC_W +: ACC_W]
//   result_valid/ready  result handshake
//   sat[SIZE]           sticky per-lane saturation flags (live)
//   overrun             sticky: result overwritten before it was consumed

// One lane: operand capture, registered full-width product, saturating acc.
module mac_lane #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     load_en,
   input  logic                     mult_en,
   input  logic                     acc_en,
   input  logic                     sel,
   input  logic        [DATA_W-1:0] a,
   input  logic        [DATA_W-1:0] b,
   output logic        [ACC_W-1:0]  acc,
   output logic                     sat
);
   localparam int PW = 2 * DATA_W;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [DATA_W-1:0] a_reg, b_reg;
   logic signed [PW-1:0]     prod, mul;
   logic        [ACC_W:0]    sum;
   logic        [ACC_W-1:0]  acc_nxt;
   logic                     ovf;

   assign mul = a_reg * b_reg;

   // One guard bit: overflow shows up as the two top bits disagreeing, and
   // the guard bit then carries the true sign of the unclamped sum.
   always_comb begin
      sum     = {acc[ACC_W-1], acc} + {{(ACC_W+1-PW){prod[PW-1]}}, prod};
      acc_nxt = sum[ACC_W-1:0];
      ovf     = 1'b0;
      if (sum[ACC_W] != sum[ACC_W-1]) begin
         ovf     = 1'b1;
         acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   // Every stage reads pre-edge register values, so simultaneous strobes
   // behave as a pipeline (load+mult multiplies the old operands).
   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg <= '0;
         b_reg <= '0;
         prod  <= '0;
         acc   <= '0;
         sat   <= 1'b0;
      end else if (clear) begin
         prod  <= '0;
         acc   <= '0;
         sat   <= 1'b0;
      end else if (sel) begin
         if (load_en) begin
            a_reg <= a;
            b_reg <= b;
         end
         if (mult_en) prod <= mul;
         if (acc_en) begin
            acc <= acc_nxt;
            if (ovf) sat <= 1'b1;
         end
      end
   end
endmodule

module mac_lane_array #(
   parameter int SIZE   = 16,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   load_en,
   input  logic                   mult_en,
   input  logic                   acc_en,
   input  logic [SIZE-1:0]        memsel,
   input  logic                   done,
   input  logic [SIZE*DATA_W-1:0] a_in,
   input  logic [SIZE*DATA_W-1:0] b_in,
   output logic [SIZE*ACC_W-1:0]  result,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [SIZE-1:0]        sat,
   output logic                   overrun
);
   // Packed lane view; lane i occupies [i*ACC_W +: ACC_W] when flattened.
   logic [SIZE-1:0][ACC_W-1:0] acc_lane;

   for (genvar i = 0; i < SIZE; i++) begin : g_lane
      mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
         .clk     (clk),
         .reset   (reset),
         .clear   (clear),
         .load_en (load_en),
         .mult_en (mult_en),
         .acc_en  (acc_en),
         .sel     (memsel[i]),
         .a       (a_in[i*DATA_W +: DATA_W]),
         .b       (b_in[i*DATA_W +: DATA_W]),
         .acc     (acc_lane[i]),
         .sat     (sat[i])
      );
   end

   // done is a sequencer strobe and is ignored alongside clear; the consumer
   // handshake is not, so a transfer during clear still retires the result.
   always_ff @(posedge clk) begin
      if (reset) begin
         result       <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else if (clear) begin
         overrun <= 1'b0;
         if (result_valid && result_ready) result_valid <= 1'b0;
      end else if (done) begin
         result       <= acc_lane;
         result_valid <= 1'b1;
         if (result_valid && !result_ready) overrun <= 1'b1;
      end else if (result_valid && result_ready) begin
         result_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mac_lane_array.sv
module tb_mac_lane_array;
   logic        clk = 1'b0;
   logic        reset = 1'b0, clear = 1'b0;
   logic        load_en = 1'b0, mult_en = 1'b0, acc_en = 1'b0, done = 1'b0;
   logic [3:0]  memsel = '0;
   logic [31:0] a_in = '0, b_in = '0;
   logic        result_ready = 1'b0;
   logic [95:0] result24;
   logic [63:0] result16;
   logic        valid24, valid16, ovr24, ovr16;
   logic [3:0]  sat24, sat16;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   mac_lane_array #(.SIZE(4), .DATA_W(8), .ACC_W(24)) u_dut (
      .clk(clk), .reset(reset), .clear(clear), .load_en(load_en),
      .mult_en(mult_en), .acc_en(acc_en), .memsel(memsel), .done(done),
      .a_in(a_in), .b_in(b_in), .result(result24), .result_valid(valid24),
      .result_ready(result_ready), .sat(sat24), .overrun(ovr24));

   mac_lane_array #(.SIZE(4), .DATA_W(8), .ACC_W(16)) u_dut16 (
      .clk(clk), .reset(reset), .clear(clear), .load_en(load_en),
      .mult_en(mult_en), .acc_en(acc_en), .memsel(memsel), .done(done),
      .a_in(a_in), .b_in(b_in), .result(result16), .result_valid(valid16),
      .result_ready(result_ready), .sat(sat16), .overrun(ovr16));

   function automatic int r24(input int i);
      return int'($signed(result24[i*24 +: 24]));
   endfunction
   function automatic int r16(input int i);
      return int'($signed(result16[i*16 +: 16]));
   endfunction

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; tick(); reset = 1'b0;
   endtask

   task automatic pulse(input logic l, input logic m, input logic a, input logic d);
      load_en = l; mult_en = m; acc_en = a; done = d;
      tick();
      load_en = 1'b0; mult_en = 1'b0; acc_en = 1'b0; done = 1'b0;
   endtask

   task automatic set_ab(input int a0, a1, a2, a3, b0, b1, b2, b3);
      int av[4], bv[4];
      av = '{a0, a1, a2, a3}; bv = '{b0, b1, b2, b3};
      for (int i = 0; i < 4; i++) begin
         a_in[i*8 +: 8] = av[i][7:0];
         b_in[i*8 +: 8] = bv[i][7:0];
      end
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (result24 !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result24); end
      checks++; if (valid24 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid24); end
      checks++; if (sat24 !== 4'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", sat24); end
      checks++; if (ovr24 !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", ovr24); end
   endtask

   task automatic test_basic;
      int exp[4];
      exp = '{12, -30, -63, 16129};
      do_reset();
      memsel = 4'hF;
      set_ab(3, 5, -7, 127, 4, -6, 9, 127);
      pulse(1, 0, 0, 0); pulse(0, 1, 0, 0); pulse(0, 0, 1, 0);
      checks++; if (valid24 !== 1'b0) begin failures++; $display("FAIL basic_valid_pre got=%b exp=0", valid24); end
      pulse(0, 0, 0, 1);
      checks++; if (valid24 !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", valid24); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (r24(i) !== exp[i]) begin failures++; $display("FAIL basic_lane%0d got=%0d exp=%0d", i, r24(i), exp[i]); end
      end
      checks++; if (sat24 !== 4'b0) begin failures++; $display("FAIL basic_sat got=%b exp=0", sat24); end
      result_ready = 1'b1; tick(); result_ready = 1'b0;
      checks++; if (valid24 !== 1'b0) begin failures++; $display("FAIL basic_consume got=%b exp=0", valid24); end
   endtask

   task automatic test_two_rounds;
      do_reset();
      memsel = 4'b0001;
      set_ab(2, 9, 9, 9, 3, 9, 9, 9);
      pulse(1, 0, 0, 0); pulse(0, 1, 0, 0); pulse(0, 0, 1, 0);
      set_ab(-4, 9, 9, 9, 5, 9, 9, 9);
      pulse(1, 0, 0, 0); pulse(0, 1, 0, 0); pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      checks++; if (r24(0) !== -14) begin failures++; $display("FAIL rounds_lane0 got=%0d exp=-14", r24(0)); end
      for (int i = 1; i < 4; i++) begin
         checks++; if (r24(i) !== 0) begin failures++; $display("FAIL rounds_lane%0d got=%0d exp=0", i, r24(i)); end
      end
   endtask

   task automatic test_saturation;
      do_reset();
      result_ready = 1'b1;
      memsel = 4'b0011;
      set_ab(127, -128, 0, 0, 127, 127, 0, 0);
      pulse(1, 0, 0, 0); pulse(0, 1, 0, 0); pulse(0, 0, 1, 0); pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      checks++; if (r16(0) !== 32258) begin failures++; $display("FAIL sat_pre_lane0 got=%0d exp=32258", r16(0)); end
      checks++; if (r16(1) !== -32512) begin failures++; $display("FAIL sat_pre_lane1 got=%0d exp=-32512", r16(1)); end
      checks++; if (sat16 !== 4'b0) begin failures++; $display("FAIL sat_pre_flag got=%b exp=0000", sat16); end
      pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      checks++; if (r16(0) !== 32767) begin failures++; $display("FAIL sat_lane0 got=%0d exp=32767", r16(0)); end
      checks++; if (r16(1) !== -32768) begin failures++; $display("FAIL sat_lane1 got=%0d exp=-32768", r16(1)); end
      checks++; if (sat16 !== 4'b0011) begin failures++; $display("FAIL sat_flag got=%b exp=0011", sat16); end
      checks++; if (r24(0) !== 48387) begin failures++; $display("FAIL sat_wide_lane0 got=%0d exp=48387", r24(0)); end
      checks++; if (ovr16 !== 1'b0) begin failures++; $display("FAIL sat_overrun got=%b exp=0", ovr16); end
      // acc_en alongside clear must be dropped
      clear = 1'b1; acc_en = 1'b1; tick(); clear = 1'b0; acc_en = 1'b0;
      checks++; if (sat16 !== 4'b0) begin failures++; $display("FAIL sat_clear_flag got=%b exp=0000", sat16); end
      pulse(0, 0, 0, 1);
      checks++; if (r16(0) !== 0 || r16(1) !== 0) begin failures++; $display("FAIL sat_clear_acc got=%0d,%0d exp=0,0", r16(0), r16(1)); end
      result_ready = 1'b0;
   endtask

   task automatic test_overrun;
      do_reset();
      memsel = 4'b0001;
      set_ab(3, 0, 0, 0, 4, 0, 0, 0);
      pulse(1, 0, 0, 0); pulse(0, 1, 0, 0); pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      checks++; if (r24(0) !== 12) begin failures++; $display("FAIL ovr_first got=%0d exp=12", r24(0)); end
      checks++; if (ovr24 !== 1'b0) begin failures++; $display("FAIL ovr_first_flag got=%b exp=0", ovr24); end
      pulse(0, 0, 1, 0);
      checks++; if (r24(0) !== 12) begin failures++; $display("FAIL ovr_stable got=%0d exp=12", r24(0)); end
      pulse(0, 0, 0, 1);
      checks++; if (r24(0) !== 24) begin failures++; $display("FAIL ovr_second got=%0d exp=24", r24(0)); end
      checks++; if (ovr24 !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", ovr24); end
      result_ready = 1'b1; tick(); result_ready = 1'b0;
      checks++; if (valid24 !== 1'b0) begin failures++; $display("FAIL ovr_consume got=%b exp=0", valid24); end
      checks++; if (ovr24 !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", ovr24); end
      clear = 1'b1; tick(); clear = 1'b0;
      checks++; if (ovr24 !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", ovr24); end
   endtask

   task automatic test_done_with_transfer;
      do_reset();
      memsel = 4'b0001;
      set_ab(3, 0, 0, 0, 4, 0, 0, 0);
      pulse(1, 0, 0, 0); pulse(0, 1, 0, 0); pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      pulse(0, 0, 1, 0);
      result_ready = 1'b1; pulse(0, 0, 0, 1); result_ready = 1'b0;
      checks++; if (valid24 !== 1'b1) begin failures++; $display("FAIL xfer_valid got=%b exp=1", valid24); end
      checks++; if (r24(0) !== 24) begin failures++; $display("FAIL xfer_result got=%0d exp=24", r24(0)); end
      checks++; if (ovr24 !== 1'b0) begin failures++; $display("FAIL xfer_overrun got=%b exp=0", ovr24); end
   endtask

   task automatic test_reset_midjob;
      do_reset();
      memsel = 4'hF;
      set_ab(5, 5, 5, 5, 5, 5, 5, 5);
      pulse(1, 0, 0, 0); pulse(0, 1, 0, 0); pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      checks++; if (r24(3) !== 25) begin failures++; $display("FAIL mid_prejob got=%0d exp=25", r24(3)); end
      set_ab(6, 6, 6, 6, 6, 6, 6, 6);
      pulse(1, 0, 0, 0); pulse(0, 1, 0, 0);
      do_reset();
      checks++; if (result24 !== '0) begin failures++; $display("FAIL mid_result got=%h exp=0", result24); end
      checks++; if (valid24 !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", valid24); end
      checks++; if (sat24 !== 4'b0 || ovr24 !== 1'b0) begin failures++; $display("FAIL mid_status got=%b/%b exp=0000/0", sat24, ovr24); end
      // the in-flight product must have been discarded
      pulse(0, 0, 1, 0); pulse(0, 0, 0, 1);
      checks++; if (r24(0) !== 0) begin failures++; $display("FAIL mid_prod got=%0d exp=0", r24(0)); end
      result_ready = 1'b1; tick(); result_ready = 1'b0;
      clear = 1'b1; tick(); clear = 1'b0;
      set_ab(1, 1, 1, 1, 1, 1, 1, 1);
      pulse(1, 0, 0, 0); pulse(0, 1, 0, 0); pulse(0, 0, 1, 0); pulse(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         checks++; if (r24(i) !== 1) begin failures++; $display("FAIL mid_rerun_lane%0d got=%0d exp=1", i, r24(i)); end
      end
   endtask

   task automatic test_back_to_back;
      do_reset();
      memsel = 4'b0001;
      set_ab(2, 0, 0, 0, 3, 0, 0, 0);
      pulse(1, 0, 0, 0);
      set_ab(10, 0, 0, 0, 10, 0, 0, 0);
      pulse(1, 1, 0, 0);       // prod = 2*3 (old operands)
      pulse(0, 0, 1, 0);       // acc = 6
      pulse(0, 1, 1, 0);       // acc = 12 (old prod), prod = 100
      pulse(0, 0, 1, 1);       // result = 12 (pre-edge), acc = 112
      checks++; if (r24(0) !== 12) begin failures++; $display("FAIL b2b_first got=%0d exp=12", r24(0)); end
      result_ready = 1'b1; tick(); result_ready = 1'b0;
      memsel = 4'b0000;
      set_ab(50, 50, 50, 50, 50, 50, 50, 50);
      pulse(1, 0, 0, 0); pulse(0, 1, 0, 0); pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      checks++; if (r24(0) !== 112) begin failures++; $display("FAIL b2b_second got=%0d exp=112", r24(0)); end
      checks++; if (r24(1) !== 0) begin failures++; $display("FAIL b2b_idle_lane got=%0d exp=0", r24(1)); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_two_rounds();
      test_saturation();
      test_overrun();
      test_done_with_transfer();
      test_reset_midjob();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
